// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the Mini-SRC datapath: fetch (T0-T2) plus
// per-class execute steps, with stop/halt/illegal-opcode handling.
module control_unit #(
    parameter int              IR_WIDTH = 32,
    parameter int              OPW      = 5,
    parameter logic [OPW-1:0]  NOP_OPC  = 5'b11000,
    parameter logic [OPW-1:0]  HALT_OPC = 5'b11001
) (
    input  logic                Clock,
    input  logic                Clear,
    input  logic [IR_WIDTH-1:0] IR,
    input  logic                Stop,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                PCin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                ZLowin,
    output logic                ZHighin,
    output logic                ZLowout,
    output logic                ZHighout,
    output logic                HIin,
    output logic                LOin,
    output logic                Cout,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic [OPW-1:0]      OP,
    output logic                Run,
    output logic                Illegal
);

    typedef enum logic [3:0] {
        RESET, IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
    } state_t;

    state_t state, state_nxt, boundary;

    logic [OPW-1:0] opc;
    logic           is_r, is_i, is_md, is_u, is_nop, is_halt, is_ill;
    logic           unused_ir;

    assign opc       = IR[IR_WIDTH-1 -: OPW];
    assign unused_ir = ^IR[IR_WIDTH-OPW-1:0];

    always_comb begin
        is_r    = (opc >= 5'b00011) && (opc <= 5'b01011);
        is_i    = (opc >= 5'b01100) && (opc <= 5'b01110);
        is_md   = (opc == 5'b01111) || (opc == 5'b10000);
        is_u    = (opc == 5'b10001) || (opc == 5'b10010);
        is_nop  = (opc == NOP_OPC);
        is_halt = (opc == HALT_OPC);
        is_ill  = !(is_r || is_i || is_md || is_u || is_nop || is_halt);
    end

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) state <= RESET;
        else       state <= state_nxt;
    end

    // Every instruction boundary honours Stop by parking in IDLE.
    assign boundary = Stop ? IDLE : T0;

    always_comb begin
        state_nxt = state;
        case (state)
            RESET:   state_nxt = boundary;
            IDLE:    state_nxt = Stop ? IDLE : T0;
            T0:      state_nxt = T1;
            T1:      state_nxt = T2;
            T2:      state_nxt = is_nop ? boundary : (is_halt ? HALT : T3);
            T3:      state_nxt = is_ill ? boundary : T4;
            T4:      state_nxt = is_u ? boundary : T5;
            T5:      state_nxt = is_md ? T6 : boundary;
            T6:      state_nxt = boundary;
            HALT:    state_nxt = HALT;
            default: state_nxt = RESET;
        endcase
    end

    always_comb begin
        PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; PCin = 1'b0;
        Read = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
        Yin = 1'b0; ZLowin = 1'b0; ZHighin = 1'b0; ZLowout = 1'b0;
        ZHighout = 1'b0; HIin = 1'b0; LOin = 1'b0; Cout = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        OP = '0; Run = 1'b0; Illegal = 1'b0;
        case (state)
            T0: begin
                Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowin = 1'b1;
            end
            T1: begin
                Run = 1'b1; ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
            end
            T2: begin
                Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
            end
            T3: begin
                Run = 1'b1;
                if (is_r || is_i) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_md) begin
                    Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_u) begin
                    Grb = 1'b1; Rout = 1'b1; ZLowin = 1'b1; OP = opc;
                end else if (is_ill) begin
                    Illegal = 1'b1;
                end
            end
            T4: begin
                Run = 1'b1;
                if (is_r) begin
                    Grc = 1'b1; Rout = 1'b1; ZLowin = 1'b1; OP = opc;
                end else if (is_i) begin
                    // Immediate forms reuse the register-form ALU op codes.
                    Cout = 1'b1; ZLowin = 1'b1;
                    case (opc)
                        5'b01100: OP = 5'b00011;
                        5'b01101: OP = 5'b00101;
                        default:  OP = 5'b00110;
                    endcase
                end else if (is_md) begin
                    Grb = 1'b1; Rout = 1'b1; ZLowin = 1'b1; ZHighin = 1'b1; OP = opc;
                end else if (is_u) begin
                    ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            T5: begin
                Run = 1'b1;
                if (is_md) begin
                    ZLowout = 1'b1; LOin = 1'b1;
                end else if (is_r || is_i) begin
                    ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            T6: begin
                Run = 1'b1;
                if (is_md) begin
                    ZHighout = 1'b1; HIin = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired Moore controller that sequences the Mini-SRC datapath.
- Drives the datapath's bus-select, register-load, memory and ALU control inputs through fetch (T0–T2) and per-class execute steps.
- Decodes the IR opcode, runs ALU register, immediate, mul/div and unary instructions, plus nop/halt.
- Replaces the hand-timed control sequences currently applied from benches.

Parameters:
- IR_WIDTH, 32, instruction register width.
- OPW, 5, opcode/ALU OP width; opcode = IR[31:27].
- NOP_OPC, 5'b11000, nop opcode.
- HALT_OPC, 5'b11001, halt opcode.

Ports:
- Clock  in  1  system clock, rising edge.
- Clear  in  1  reset, asynchronous, active-high.
- IR  in  32  datapath IR contents; valid from T3 onward.
- Stop  in  1  level request to idle at the next instruction boundary.
- PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin  out  1 each  fetch controls.
- Yin, ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin, Cout  out  1 each  ALU/register controls.
- Gra, Grb, Grc  out  1 each  select the IR Ra/Rb/Rc field (IR[26:23]/[22:19]/[18:15]) for select-and-encode.
- Rin, Rout  out  1 each  load/drive the selected general register.
- OP  out  5  ALU operation code.
- Run  out  1  high while executing; low in RESET, IDLE, HALT.
- Illegal  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- States: RESET, IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. State register uses async Clear.
- Outputs are decoded from state plus IR[31:27] only (Moore). Every output not listed for a state is 0.
- Clear high: state = RESET immediately, all outputs including OP and Run = 0, regardless of current state.
- RESET -> T0 on the first edge after Clear falls.
- Boundary check: wherever the next state would be T0 and Stop = 1, go to IDLE instead.
- IDLE: Run = 0. IDLE -> T0 on the first edge with Stop = 0.
- T0: PCout, MARin, IncPC, ZLowin.
- T1: ZLowout, PCin, Read, MDRin. Memory data is captured into MDR this cycle.
- T2: MDRout, IRin. IR is loaded at the end of T2.
- Class R (opcodes 00011–01011: add, sub, and, or, shr, shra, shl, ror, rol):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, ZLowin, OP = opcode.
  - T5: ZLowout, Gra, Rin; then T0.
- Class I (addi 01100, andi 01101, ori 01110):
  - T3: Grb, Rout, Yin.
  - T4: Cout, ZLowin; OP = 00011 / 00101 / 00110 respectively.
  - T5: ZLowout, Gra, Rin; then T0.
- Class MD (mul 01111, div 10000):
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, ZLowin, ZHighin, OP = opcode.
  - T5: ZLowout, LOin.
  - T6: ZHighout, HIin; then T0.
- Class U (neg 10001, not 10010):
  - T3: Grb, Rout, ZLowin, OP = opcode.
  - T4: ZLowout, Gra, Rin; then T0.
- nop: T2 -> T0 (3-cycle instruction).
- halt: T2 -> HALT. HALT holds with Run = 0 and ignores Stop; only Clear exits.
- Any other opcode: T3 with only Illegal = 1 (no datapath strobes), then T0.
- OP outside the listed states = 5'b00000.
- Run = 1 in T0–T6.
- Instruction latency, counted from T0 to the next T0: R/I 6 cycles, MD 7, U 5, nop 3, illegal 4.
- At most one bus driver is asserted per cycle (PCout, MDRout, Rout, Cout, ZLowout, ZHighout are mutually exclusive). The verifier checks this as an assertion.
- Register writes (Rin, PCin, HIin, LOin, IRin) are asserted only in the states listed above.
- A Clear during any T-state aborts the instruction: no strobe survives past the Clear edge, and the next fetch restarts at T0.

Test Plan:
- Clear pulse, then IR = 0x18918000 (add R1,R2,R3):
  - T0 PCout/MARin/IncPC/ZLowin; T1 PCin/Read/MDRin; T2 MDRout/IRin.
  - T3 Grb/Rout/Yin; T4 Grc/Rout/ZLowin with OP = 00011; T5 ZLowout/Gra/Rin.
  - Back to T0 after 6 cycles.
- IR = 0x68900000 (andi R1,R2,0) -> T4 has Cout = 1, Rout = 0, OP = 00101; 6-cycle instruction.
- IR = 0x78900000 (mul R1,R2) -> T5 ZLowout/LOin, T6 ZHighout/HIin, OP = 01111 in T4; next T0 at cycle 7.
- IR = 0xC8000000 (halt) -> Run drops after T2 and stays 0 for 20 cycles with all strobes 0; Clear then gives RESET -> T0.
- IR = 0xF8000000 (opcode 11111) -> Illegal = 1 for exactly one cycle in T3, no other strobes, T0 follows.
- Stop raised during T4 of an add -> IDLE after T5, Run = 0. Stop lowered -> T0 next edge.
- Clear raised mid-T4 -> all outputs 0 with no clock edge needed.
